// File: rtl/i2s_types.sv
// Shared types for the I2S feeder path.
// Packer FSM states and word-select encodings.
package i2s_types;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_LEFT,
    S_RIGHT
  } i2s_pack_state_t;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous stereo-frame FIFO with registered read port.
// Push on full and pop on empty are ignored.
module i2s_frame_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rdata  <= mem[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_sample_packer.sv
// Stereo frame to byte-stream packer feeding the I2S controller.
// Left MSB..LSB (ws=0) then right MSB..LSB (ws=1); counts starvation.
module i2s_sample_packer #(
  parameter int SAMPLE_W       = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int UNDERRUN_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_left,
  input  logic [SAMPLE_W-1:0]           s_right,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic                          o_ws,
  output logic [7:0]                    o_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [UNDERRUN_CNT_W-1:0]     underrun_count
);

  import i2s_types::*;

  localparam int NB    = SAMPLE_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int FW    = 2 * SAMPLE_W;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NB - 1);

  i2s_pack_state_t state_q, state_d;

  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [FW-1:0]             frame_q, frame_d;
  logic                      valid_q, valid_d;
  logic                      ws_q, ws_d;
  logic [7:0]                data_q, data_d;
  logic                      done_q, done_d;
  logic                      und_q, und_d;
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

  logic          full;
  logic          empty;
  logic          pop;
  logic          xfer;
  logic [FW-1:0] rdata;

  function automatic logic [7:0] byte_of(
    input logic [SAMPLE_W-1:0] s,
    input logic [IDX_W-1:0]    i
  );
    logic [SAMPLE_W-1:0] t;
    t = s >> {i, 3'b000};
    return t[7:0];
  endfunction

  // No bypass: a full FIFO refuses even when a pop is underway.
  assign s_ready = ~full & ~rst;
  assign xfer    = valid_q & o_ready;

  i2s_frame_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid & s_ready),
    .pop   (pop),
    .wdata ({s_left, s_right}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    valid_d = valid_q;
    ws_d    = ws_q;
    data_d  = data_q;
    done_d  = done_q;
    und_d   = und_q;
    ucnt_d  = ucnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        frame_d = rdata;
        valid_d = 1'b1;
        ws_d    = WS_LEFT;
        idx_d   = IDX_TOP;
        data_d  = byte_of(rdata[FW-1 -: SAMPLE_W], IDX_TOP);
        state_d = S_LEFT;
      end
      S_LEFT: begin
        if (xfer) begin
          if (idx_q == '0) begin
            ws_d    = WS_RIGHT;
            idx_d   = IDX_TOP;
            data_d  = byte_of(frame_q[SAMPLE_W-1:0], IDX_TOP);
            state_d = S_RIGHT;
          end else begin
            idx_d  = idx_q - 1'b1;
            data_d = byte_of(frame_q[FW-1 -: SAMPLE_W], idx_q - 1'b1);
          end
        end
      end
      S_RIGHT: begin
        if (xfer) begin
          if (idx_q == '0) begin
            valid_d = 1'b0;
            ws_d    = WS_LEFT;
            data_d  = '0;
            done_d  = 1'b1;
            if (!empty) begin
              pop     = 1'b1;
              state_d = S_LOAD;
            end else begin
              state_d = S_IDLE;
              // The very first frame after reset never counts.
              if (done_q) begin
                und_d = 1'b1;
                if (ucnt_q != '1) begin
                  ucnt_d = ucnt_q + 1'b1;
                end
              end
            end
          end else begin
            idx_d  = idx_q - 1'b1;
            data_d = byte_of(frame_q[SAMPLE_W-1:0], idx_q - 1'b1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      ws_q    <= WS_LEFT;
      data_q  <= '0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      ws_q    <= ws_d;
      data_q  <= data_d;
      done_q  <= done_d;
      und_q   <= und_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_ws           = ws_q;
  assign o_data         = data_q;
  assign underrun       = und_q;
  assign underrun_count = ucnt_q;

endmodule
